alu_op_scheduler: RTL
=====================

ALU_OP_SCHEDULER -- requirements
Module: alu_op_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width.
REQ-002 SHALL have parameter DIV_STEPS, default 16 (= DATA_W), divider iterations.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1  requester has an operation.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1  scheduler accepts that requester.
REQ-007 SHALL have ports req0_op, req1_op  input  4  opcode: 0 add, 1 sub, 2 mul, 3 div, 4/5 shl/shr op1, 6/7 shl/shr op2, 8 and, 9 or, 10 xor.
REQ-008 SHALL have ports req0_operand1/2, req1_operand1/2  input  DATA_W  operands.
REQ-009 SHALL have port rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts.
REQ-010 SHALL have ports rsp_id  output  1  granted requester; rsp_result, rsp_rest_result  output  DATA_W; rsp_zero, rsp_err  output  1.

Function
REQ-011 SHALL run FSM IDLE -> EXEC -> RESP for ops other than div, IDLE -> DIV -> RESP for div; RESP -> IDLE on rsp_valid & rsp_ready.
REQ-012 SHALL drive reqN_ready high only in IDLE and only for the requester currently granted; handshake = valid & ready captures op, operands, id.
REQ-013 SHALL arbitrate round-robin: both valid -> grant priority holder; single valid -> grant it; priority passes to the other requester after every grant.
REQ-014 SHALL not let a requester drop or change payload matter: only the captured copy is used after handshake.
REQ-015 SHALL assert rsp_valid exactly 2 cycles after capture edge for non-div ops, DIV_STEPS+2 cycles for div with nonzero divisor.
REQ-016 SHALL hold all rsp_* outputs stable while rsp_valid & !rsp_ready.
REQ-017 SHALL compute add/sub/mul modulo 2^DATA_W (mul = low DATA_W bits), shifts by one with zero fill.
REQ-018 SHALL compute div by restoring algorithm, one quotient bit per cycle, unsigned; result = quotient, rest_result = remainder.
REQ-019 SHALL on divisor 0: skip iteration (2-cycle latency), result all ones, rest_result = operand1, rsp_err = 1.
REQ-020 SHALL on opcode 11..15: result 0, rsp_err = 1, 2-cycle latency.
REQ-021 SHALL drive rsp_rest_result 0 for every non-div op.
REQ-022 SHALL set rsp_zero = 1 iff rsp_result == 0.
REQ-023 SHALL accept no new request before the current response is consumed (one op in flight); a new handshake may occur the cycle after RESP exits.

Reset
REQ-024 SHALL on rst_n low at a clock edge: FSM IDLE, priority to requester 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_rest_result 0, rsp_zero 0, rsp_err 0, divider state cleared.
REQ-025 SHALL abandon any in-flight operation, including mid-divide, with no response emitted; reqN_ready 0 while rst_n low.

Structure
REQ-026 SHALL place opcode constants, FSM state encoding and DATA_W default in shared package alu_pkg.
REQ-027 SHALL implement the iterative divider as sub-module seq_divider (start, busy, done, quotient, remainder); other ops combinational inside alu_op_scheduler.

Verification
REQ-028 req0 add 5+3, rsp_ready=1 -> rsp_valid 2 cycles after capture, result 8, id 0, zero 0, err 0.
REQ-029 req1 div 7/2 -> after 18 cycles result 3, rest 1; div 5/0 -> 2 cycles, result 16'hFFFF, rest 5, err 1.
REQ-030 req0 and req1 valid continuously, sub 5-3 each -> grants alternate 0,1,0,1 starting with 0; results 2.
REQ-031 xor 5^5 with rsp_ready low 4 cycles -> rsp_valid held, result 0, zero 1, outputs stable; no new grant until accept.
REQ-032 rst_n low at divide step 8 -> next edge all outputs reset values, no response; next request handled normally, req0 priority.
REQ-033 opcode 12 -> result 0, zero 1, err 1; sub 3-5 -> 16'hFFFE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operation scheduler: opcodes, FSM encoding
// and the default datapath width.
package alu_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHL1 = 4'd4;
  localparam logic [3:0] OP_SHR1 = 4'd5;
  localparam logic [3:0] OP_SHL2 = 4'd6;
  localparam logic [3:0] OP_SHR2 = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// A start pulse loads the operands; done pulses for one cycle once the
// final quotient/remainder are sitting in the output registers.
module seq_divider
  import alu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_STEPS + 1);

  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   trial;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, subtract the divisor when it fits.
  always_comb begin
    trial  = {rem_q, quo_q[DATA_W-1]};
    fits   = (trial >= {1'b0, dvs_q});
    diff   = trial[DATA_W-1:0] - dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = CNT_W'(DIV_STEPS);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = fits ? diff : trial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], fits};
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Divider state registers; reset drops any partial divide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/alu_op_scheduler.sv
// Two-requester ALU front end: round-robin grant, one operation in flight,
// registered response held until the consumer takes it.
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV_STEPS = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_operand1,
  input  logic [DATA_W-1:0] req0_operand2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_operand1,
  input  logic [DATA_W-1:0] req1_operand2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_rest_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  // Requesters packed so the grant index selects the payload directly.
  logic [1:0]             rq_vld;
  logic [1:0][3:0]        rq_op;
  logic [1:0][DATA_W-1:0] rq_a, rq_b;

  assign rq_vld = {req1_valid, req0_valid};
  assign rq_op  = {req1_op, req0_op};
  assign rq_a   = {req1_operand1, req0_operand1};
  assign rq_b   = {req1_operand2, req0_operand2};

  state_e state_q, state_d;
  logic   prio_q;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;

  logic [DATA_W-1:0] stg_res_q, stg_rest_q;
  logic              stg_err_q;

  logic              rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_result_q, rsp_rest_q;

  logic              any_v, gnt_id, idle, hs, div_go, div_start;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;

  logic              div_busy, div_done;
  logic [DATA_W-1:0] div_quo, div_rem;

  logic [DATA_W-1:0] alu_res, alu_rest;
  logic              alu_err;

  // Round-robin: on contention the priority holder wins, otherwise the
  // lone valid requester wins. Ready is only offered from IDLE.
  assign any_v      = |rq_vld;
  assign gnt_id     = (&rq_vld) ? prio_q : rq_vld[1];
  assign idle       = (state_q == ST_IDLE);
  assign hs         = rst_n & idle & any_v;
  assign req0_ready = hs & ~gnt_id;
  assign req1_ready = hs & gnt_id;

  assign sel_op    = rq_op[gnt_id];
  assign sel_a     = rq_a[gnt_id];
  assign sel_b     = rq_b[gnt_id];
  // Divide by zero takes the short EXEC path; only real divides iterate.
  assign div_go    = (sel_op == OP_DIV) && (sel_b != '0);
  assign div_start = hs & div_go & ~div_busy;

  seq_divider #(
    .DATA_W    (DATA_W),
    .DIV_STEPS (DIV_STEPS)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (sel_a),
    .divisor   (sel_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // Single-cycle ops on the captured operands.
  always_comb begin
    alu_res  = '0;
    alu_rest = '0;
    alu_err  = 1'b0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_MUL:  alu_res = a_q * b_q;
      OP_DIV: begin
        alu_res  = '1;
        alu_rest = a_q;
        alu_err  = 1'b1;
      end
      OP_SHL1: alu_res = {a_q[DATA_W-2:0], 1'b0};
      OP_SHR1: alu_res = {1'b0, a_q[DATA_W-1:1]};
      OP_SHL2: alu_res = {b_q[DATA_W-2:0], 1'b0};
      OP_SHR2: alu_res = {1'b0, b_q[DATA_W-1:1]};
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_err = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = div_go ? ST_DIV : ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_DIV:  if (div_done) state_d = ST_RESP;
      ST_RESP: if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture on handshake, stage the result, then publish it one cycle
  // after entering RESP and hold it until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      stg_res_q    <= '0;
      stg_rest_q   <= '0;
      stg_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_rest_q   <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (hs) begin
        op_q   <= sel_op;
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= gnt_id;
        prio_q <= ~gnt_id;
      end
      case (state_q)
        ST_EXEC: begin
          stg_res_q  <= alu_res;
          stg_rest_q <= alu_rest;
          stg_err_q  <= alu_err;
        end
        ST_DIV: if (div_done) begin
          stg_res_q  <= div_quo;
          stg_rest_q <= div_rem;
          stg_err_q  <= 1'b0;
        end
        ST_RESP: begin
          if (!rsp_valid_q) begin
            rsp_valid_q  <= 1'b1;
            rsp_id_q     <= id_q;
            rsp_result_q <= stg_res_q;
            rsp_rest_q   <= stg_rest_q;
            rsp_zero_q   <= (stg_res_q == '0);
            rsp_err_q    <= stg_err_q;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_rest_result = rsp_rest_q;
  assign rsp_zero        = rsp_zero_q;
  assign rsp_err         = rsp_err_q;

endmodule
